// File: rtl/vmx_array_seq.sv
// Job sequencer for a chained PE array: weight load, data stream, drain, and a credit-guarded result FIFO.
// Optional cycle counter output perf_cycles is enabled by defining VMX_SEQ_PERF_CNT_EN.
module vmx_array_seq #(
  parameter int N_PE           = 8,
  parameter int VECTOR_BITLEN  = 16,
  parameter int PRODUCT_BITLEN = 32,
  parameter int LEN_W          = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      simd_mode_cfg,
  input  logic [LEN_W-1:0]          vec_len,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VECTOR_BITLEN-1:0]  in_data,
  output logic [VECTOR_BITLEN-1:0]  pe_data,
  output logic [7:0]                pe_is_weight,
  output logic                      pe_simd_mode,
  output logic [PRODUCT_BITLEN-1:0] pe_sum_in,
  input  logic [PRODUCT_BITLEN-1:0] arr_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PRODUCT_BITLEN-1:0] out_data
`ifdef VMX_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]               perf_cycles
`endif
);

  localparam int WW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(N_PE + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic                      simd_q;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          s_cnt;
  logic [WW-1:0]             w_cnt;
  logic [N_PE-1:0]           valid_sr;
  logic [IW-1:0]             inflight;
  logic [PRODUCT_BITLEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             fifo_cnt;

  logic start_acc, load_xfer, stream_xfer, push, pop, credit_ok, w_last, s_last;

  // Transfers are derived without in_ready to keep the handshake free of comb loops.
  assign start_acc   = (state == IDLE) && start;
  assign credit_ok   = (32'(fifo_cnt) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign load_xfer   = in_valid && (state == LOAD_W);
  assign stream_xfer = in_valid && (state == STREAM) && credit_ok;
  assign push        = valid_sr[N_PE-1];
  assign pop         = out_valid && out_ready;
  assign w_last      = (w_cnt == WW'(N_PE - 1));
  assign s_last      = (s_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_W;
      LOAD_W:  if (load_xfer && w_last) state_next = (len_q == '0) ? DRAIN : STREAM;
      STREAM:  if (stream_xfer && s_last) state_next = DRAIN;
      DRAIN:   if (inflight == IW'(push)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    in_ready     = 1'b0;
    pe_data      = '0;
    pe_is_weight = 8'hFF;
    pe_sum_in    = '0;
    case (state)
      LOAD_W:  in_ready = 1'b1;
      STREAM:  in_ready = credit_ok;
      default: in_ready = 1'b0;
    endcase
    if (load_xfer) begin
      pe_data      = in_data;
      pe_is_weight = 8'(N_PE - 1) - 8'(w_cnt);
    end else if (stream_xfer) begin
      pe_data      = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      simd_q <= 1'b0;
      len_q  <= '0;
      w_cnt  <= '0;
      s_cnt  <= '0;
    end else if (start_acc) begin
      simd_q <= simd_mode_cfg;
      len_q  <= vec_len;
      w_cnt  <= '0;
      s_cnt  <= '0;
    end else begin
      if (load_xfer)   w_cnt <= w_cnt + WW'(1);
      if (stream_xfer) s_cnt <= s_cnt + LEN_W'(1);
    end
  end

  assign pe_simd_mode = simd_q;

  // Each bit marks a stream word still travelling through the PE chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      inflight <= '0;
    end else begin
      valid_sr[0] <= stream_xfer;
      for (int i = 1; i < N_PE; i++) valid_sr[i] <= valid_sr[i-1];
      if (stream_xfer && !push)      inflight <= inflight + IW'(1);
      else if (!stream_xfer && push) inflight <= inflight - IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= arr_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = mem[rd_ptr];

`ifdef VMX_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              perf_cycles <= '0;
    else if (start_acc)                      perf_cycles <= '0;
    else if (busy && perf_cycles != '1)      perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vmx_array_seq.sv
// Randomized bench for vmx_array_seq: a job-level queue model predicts handshakes, PE drive and results.
module tb_vmx_array_seq;

  localparam int N_PE = 8;
  localparam int VB   = 16;
  localparam int PB   = 32;
  localparam int LW   = 8;
  localparam int FD   = 16;

  logic          clk, rst_n, start, simd_mode_cfg;
  logic [LW-1:0] vec_len;
  logic          busy, done, in_valid, in_ready;
  logic [VB-1:0] in_data, pe_data;
  logic [7:0]    pe_is_weight;
  logic          pe_simd_mode;
  logic [PB-1:0] pe_sum_in, arr_sum, out_data;
  logic          out_valid, out_ready;
`ifdef VMX_SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  vmx_array_seq #(
    .N_PE(N_PE), .VECTOR_BITLEN(VB), .PRODUCT_BITLEN(PB), .LEN_W(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .simd_mode_cfg(simd_mode_cfg), .vec_len(vec_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pe_data(pe_data), .pe_is_weight(pe_is_weight), .pe_simd_mode(pe_simd_mode),
    .pe_sum_in(pe_sum_in), .arr_sum(arr_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef VMX_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: job phase, words left, in-flight push times and expected FIFO contents.
  typedef enum {M_IDLE, M_LOAD, M_STREAM, M_DRAIN, M_DONE} phase_t;
  phase_t        m_phase = M_IDLE;
  int            m_widx, m_sleft, m_len;
  logic          m_simd = 1'b0;
  int            pend_q[$];
  logic [PB-1:0] fifo_q[$];
  int            cyc = 0;
  int            job_pushes = 0;
  int            done_cnt = 0;
  bit            job_done_seen = 0;

  always @(negedge clk) begin
    bit            exp_ready, xfer, pop;
    logic [7:0]    exp_w;
    logic [VB-1:0] exp_d;
    cyc++;
    if (done) done_cnt++;
    if (!rst_n) begin
      checkOutput("rst_busy", 64'(busy), 0);
      checkOutput("rst_done", 64'(done), 0);
      checkOutput("rst_in_ready", 64'(in_ready), 0);
      checkOutput("rst_out_valid", 64'(out_valid), 0);
      checkOutput("rst_pe_is_weight", 64'(pe_is_weight), 64'hFF);
      checkOutput("rst_pe_data", 64'(pe_data), 0);
      checkOutput("rst_pe_simd_mode", 64'(pe_simd_mode), 0);
      m_phase = M_IDLE;
      m_simd  = 1'b0;
      pend_q.delete();
      fifo_q.delete();
    end else begin
      exp_ready = (m_phase == M_LOAD) ||
                  (m_phase == M_STREAM && (fifo_q.size() + pend_q.size()) < FD);
      xfer  = in_valid && exp_ready;
      exp_w = (m_phase == M_LOAD && xfer) ? 8'(N_PE - 1 - m_widx) : 8'hFF;
      exp_d = xfer ? in_data : '0;
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
      checkOutput("busy", 64'(busy), 64'(m_phase != M_IDLE));
      checkOutput("done", 64'(done), 64'(m_phase == M_DONE));
      checkOutput("pe_is_weight", 64'(pe_is_weight), 64'(exp_w));
      checkOutput("pe_data", 64'(pe_data), 64'(exp_d));
      checkOutput("pe_sum_in", 64'(pe_sum_in), 0);
      checkOutput("pe_simd_mode", 64'(pe_simd_mode), 64'(m_simd));
      checkOutput("out_valid", 64'(out_valid), 64'(fifo_q.size() != 0));
      if (fifo_q.size() != 0) checkOutput("out_data", 64'(out_data), 64'(fifo_q[0]));

      pop = (fifo_q.size() != 0) && out_ready;
      if (pop) void'(fifo_q.pop_front());
      if (pend_q.size() != 0 && pend_q[0] == cyc) begin
        void'(pend_q.pop_front());
        fifo_q.push_back(arr_sum);
        job_pushes++;
      end
      if (m_phase == M_STREAM && xfer) pend_q.push_back(cyc + N_PE);

      case (m_phase)
        M_IDLE: if (start) begin
          m_phase = M_LOAD; m_widx = 0; m_len = int'(vec_len); m_simd = simd_mode_cfg;
        end
        M_LOAD: if (xfer) begin
          m_widx++;
          if (m_widx == N_PE) begin
            if (m_len == 0) m_phase = M_DRAIN;
            else begin m_phase = M_STREAM; m_sleft = m_len; end
          end
        end
        M_STREAM: if (xfer) begin
          m_sleft--;
          if (m_sleft == 0) m_phase = M_DRAIN;
        end
        M_DRAIN: if (pend_q.size() == 0) begin m_phase = M_DONE; job_done_seen = 1; end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic applyStimulus(input logic s, input logic [LW-1:0] len, input logic simd,
                               input logic iv, input logic ordy);
    start = s; vec_len = len; simd_mode_cfg = simd; in_valid = iv; out_ready = ordy;
    in_data = VB'($urandom); arr_sum = $urandom;
    @(posedge clk); #1;
  endtask

  // vmode/rmode: 0 = always high, 1 = toggling / held low, 2 = random.
  task automatic runJob(input int len, input logic simd, input int vmode, input int rmode,
                        input int stall, input int inj_at);
    logic iv, ordy;
    job_done_seen = 0;
    job_pushes    = 0;
    applyStimulus(1'b1, LW'(len), simd, 1'b1, 1'b1);
    for (int d = 0; d < 800 && !job_done_seen; d++) begin
      iv   = (vmode == 0) ? 1'b1 : (vmode == 1) ? ~d[0] : 1'($urandom_range(0, 1));
      ordy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (d < stall) ordy = 1'b0;
      applyStimulus(d == inj_at, LW'(3), ~simd, iv, ordy);
      if (stall > 0 && d == stall - 1) begin
        checkOutput("credit_in_ready", 64'(in_ready), 0);
        checkOutput("credit_out_valid", 64'(out_valid), 1);
      end
    end
    if (!job_done_seen) checkOutput("job_timeout", 0, 1);
    else                checkOutput("result_count", 64'(job_pushes), 64'(len));
  endtask

  task automatic drainFifo();
    int d;
    d = 0;
    do begin
      applyStimulus(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      d++;
    end while ((fifo_q.size() != 0 || d < 2) && d < 100);
    checkOutput("drained_out_valid", 64'(out_valid), 0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 0; vec_len = '0; simd_mode_cfg = 0; in_valid = 0; in_data = '0;
    arr_sum = '0; out_ready = 1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("[TB] basic job, vec_len=4");
    runJob(4, 1'b1, 0, 0, 0, -1);
    drainFifo();
`ifdef VMX_SEQ_PERF_CNT_EN
    checkOutput("perf_cycles", 64'(perf_cycles), 64'(8 + 4 + N_PE + 1));
`endif

    $display("[TB] vec_len=0");
    runJob(0, 1'b0, 0, 0, 0, -1);
    drainFifo();

    $display("[TB] credit stall, vec_len=40");
    runJob(40, 1'b0, 0, 0, 80, -1);
    drainFifo();

    $display("[TB] start during stream, toggling valid");
    runJob(20, 1'b1, 1, 0, 0, 12);
    drainFifo();

    $display("[TB] random jobs");
    for (int j = 0; j < 6; j++) begin
      runJob($urandom_range(0, 24), 1'($urandom_range(0, 1)), 2, 2, 0, -1);
      drainFifo();
    end

    $display("[TB] reset during drain");
    job_done_seen = 0;
    applyStimulus(1'b1, LW'(4), 1'b1, 1'b1, 1'b0);
    for (int d = 0; d < 100 && !(m_phase == M_DRAIN && fifo_q.size() == 3); d++)
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    if (!(m_phase == M_DRAIN && fifo_q.size() == 3)) checkOutput("reach_drain_timeout", 0, 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 0);
    checkOutput("abort_busy", 64'(busy), 0);
    checkOutput("abort_pe_is_weight", 64'(pe_is_weight), 64'hFF);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    for (int d = 0; d < 20; d++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_no_done", 64'(done_cnt), 64'(dc));
    checkOutput("abort_job_not_done", 64'(job_done_seen), 0);

    $display("[TB] job after abort");
    runJob(5, 1'b0, 2, 2, 0, -1);
    drainFifo();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
